// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the RV32M multiply sequencer
package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_e;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, RESP, HIT} mul_state_e;

    typedef enum logic [1:0] {CLS_S, CLS_SU, CLS_U} sign_class_e;

    // MUL and MULH share a product, so they share a signedness class
    function automatic sign_class_e sign_class(input mul_op_e op);
        return op == MULHSU ? CLS_SU : op == MULHU ? CLS_U : CLS_S;
    endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add step folding a multiplier slice into the accumulator
module mul_step #(
    parameter int XLEN = 32,
    parameter int BITS = 4
) (
    input  logic [2*XLEN-1:0]         acc,
    input  logic [XLEN-1:0]           opb,
    input  logic [BITS-1:0]           bits,
    input  logic [$clog2(2*XLEN)-1:0] shamt,
    output logic [2*XLEN-1:0]         acc_next
);

    logic [2*XLEN-1:0] pp;

    // zero-extended partial product, shifted to its bit position and accumulated
    always_comb begin
        pp       = {{XLEN{1'b0}}, opb} * {{(2*XLEN-BITS){1'b0}}, bits};
        acc_next = acc + (pp << shamt);
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative RV32M multiply sequencer with a one-entry result cache
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS);
    localparam int SW    = $clog2(2 * XLEN);

    mul_state_e        state, nxt;
    mul_op_e           op;
    logic [XLEN-1:0]   rs1, rs2, opa, opb, a_abs, b_abs;
    logic              neg;
    logic [2*XLEN-1:0] acc, acc_next;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     shamt;
    logic              c_valid;
    logic [XLEN-1:0]   c_rs1, c_rs2;
    sign_class_e       c_cls;
    logic [2*XLEN-1:0] c_prod;
    logic              accept, hit;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP || state == HIT;
    assign busy       = state != IDLE;
    assign resp_data  = !resp_valid ? '0 : op == MUL ? c_prod[XLEN-1:0] : c_prod[2*XLEN-1:XLEN];
    assign accept     = req_valid && req_ready && !flush;
    assign hit        = c_valid && req_rs1 == c_rs1 && req_rs2 == c_rs2
                        && c_cls == sign_class(mul_op_e'(req_op));
    assign a_abs      = rs1[XLEN-1] ? -rs1 : rs1;
    assign b_abs      = rs2[XLEN-1] ? -rs2 : rs2;
    assign shamt      = SW'(cnt * BITS_PER_CYCLE);

    mul_step #(.XLEN(XLEN), .BITS(BITS_PER_CYCLE)) u_step (
        .acc      (acc),
        .opb      (opb),
        .bits     (opa[BITS_PER_CYCLE-1:0]),
        .shamt    (shamt),
        .acc_next (acc_next)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next-state logic; flush overrides every transition
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:      if (accept) nxt = hit ? HIT : PREP;
            PREP:      nxt = ITER;
            ITER:      if (cnt == CW'(ITERS - 1)) nxt = FIX;
            FIX:       nxt = RESP;
            RESP, HIT: if (resp_ready) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    // operand capture, magnitude prep, shift-add iteration and cache fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= MUL;
            rs1     <= '0;
            rs2     <= '0;
            opa     <= '0;
            opb     <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            c_valid <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_cls   <= CLS_S;
            c_prod  <= '0;
        end else begin
            if (accept) begin
                op  <= mul_op_e'(req_op);
                rs1 <= req_rs1;
                rs2 <= req_rs2;
            end
            if (state == PREP) begin
                opa <= op == MULHU ? rs1 : a_abs;
                opb <= (op == MUL || op == MULH) ? b_abs : rs2;
                neg <= op == MULHU ? 1'b0 : op == MULHSU ? rs1[XLEN-1] : rs1[XLEN-1] ^ rs2[XLEN-1];
                acc <= '0;
                cnt <= '0;
            end
            if (state == ITER) begin
                acc <= acc_next;
                opa <= opa >> BITS_PER_CYCLE;
                cnt <= cnt + CW'(1);
            end
            if (state == FIX && !flush) begin
                c_valid <= 1'b1;
                c_rs1   <= rs1;
                c_rs2   <= rs2;
                c_cls   <= sign_class(op);
                c_prod  <= neg ? -acc : acc;
            end
        end
    end

endmodule
